// File: rtl/nfmac10g_pkg.sv
// ============================================================================
// Module   : nfmac10g_pkg
// Brief    : Shared constants and state encoding for the nfmac10g tx path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nfmac10g_pkg;

    localparam logic [47:0] PAUSE_DA        = 48'h0180C2000001;
    localparam logic [15:0] ETYPE_MAC_CTRL  = 16'h8808;
    localparam logic [15:0] OPC_PAUSE       = 16'h0001;
    localparam int unsigned PAUSE_BEATS     = 8;
    localparam logic [7:0]  PAUSE_LAST_KEEP = 8'h0F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLIENT = 2'd1,
        PAUSE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pause_frm_gen.sv
// ============================================================================
// Module   : pause_frm_gen
// Brief    : Combinational 802.3x PAUSE frame beat builder (byte n on [8n+7:8n]).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pause_frm_gen
    import nfmac10g_pkg::*;
(
    input  logic [2:0]  beat_i,
    input  logic [47:0] sa_i,
    input  logic [15:0] ptime_i,
    output logic [63:0] tdata_o,
    output logic [7:0]  tkeep_o,
    output logic        tlast_o
);

    localparam logic [2:0] LAST_BEAT = 3'(PAUSE_BEATS - 1);

    always_comb begin
        tdata_o = '0;
        tkeep_o = 8'hFF;
        tlast_o = 1'b0;
        case (beat_i)
            3'd0: tdata_o = {sa_i[39:32], sa_i[47:40],
                             PAUSE_DA[7:0], PAUSE_DA[15:8], PAUSE_DA[23:16],
                             PAUSE_DA[31:24], PAUSE_DA[39:32], PAUSE_DA[47:40]};
            3'd1: tdata_o = {OPC_PAUSE[7:0], OPC_PAUSE[15:8],
                             ETYPE_MAC_CTRL[7:0], ETYPE_MAC_CTRL[15:8],
                             sa_i[7:0], sa_i[15:8], sa_i[23:16], sa_i[31:24]};
            3'd2: tdata_o = {48'h0, ptime_i[7:0], ptime_i[15:8]};
            LAST_BEAT: begin
                // 60 bytes total; the datapath pads nothing and appends FCS
                tkeep_o = PAUSE_LAST_KEEP;
                tlast_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tx_pause_sched.sv
// ============================================================================
// Module   : tx_pause_sched
// Brief    : Arbitrates client frames and generated PAUSE frames onto the tx
//            datapath on frame boundaries. Optional XON via PAUSE_XON_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_pause_sched
    import nfmac10g_pkg::*;
#(
    parameter int C_QUANTA_CYCLES = 8,
    parameter int C_TIMER_W       = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_req,
    input  logic [15:0] pause_val,
    input  logic [47:0] cfg_station_macaddr,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        pause_sent
);

    localparam logic [2:0] LAST_BEAT = 3'(PAUSE_BEATS - 1);

    state_t               state_q;
    logic [2:0]           beat_q;
    logic [15:0]          ptime_q;
    logic                 pend_q, pend_d;
    logic                 pause_req_q;
    logic [C_TIMER_W-1:0] timer_q, timer_d;
    logic [C_TIMER_W-1:0] w_load;
    logic                 w_rise, w_expire, w_set, w_pause_sent, w_reload;
    logic [63:0]          w_gen_tdata;
    logic [7:0]           w_gen_tkeep;
    logic                 w_gen_tlast;
`ifdef PAUSE_XON_EN
    logic                 w_fall, xon_q, xon_d, frame_xon_q;
`endif

    pause_frm_gen u_frm_gen (
        .beat_i  (beat_q),
        .sa_i    (cfg_station_macaddr),
        .ptime_i (ptime_q),
        .tdata_o (w_gen_tdata),
        .tkeep_o (w_gen_tkeep),
        .tlast_o (w_gen_tlast)
    );

    always_comb begin
        w_rise       = pause_req & ~pause_req_q;
        w_expire     = pause_req & (timer_q == C_TIMER_W'(1));
        w_pause_sent = (state_q == PAUSE) & (beat_q == LAST_BEAT) & m_axis_tready;
`ifdef PAUSE_XON_EN
        w_fall   = ~pause_req & pause_req_q;
        w_set    = w_rise | w_expire | w_fall;
        w_reload = w_pause_sent & ~frame_xon_q;
        // A later rising edge supersedes a pending XON; the flag is consumed at frame start
        xon_d = xon_q;
        if (w_fall)
            xon_d = 1'b1;
        else if (w_rise)
            xon_d = 1'b0;
        else if ((state_q == IDLE) && pend_q)
            xon_d = 1'b0;
`else
        w_set    = w_rise | w_expire;
        w_reload = w_pause_sent;
`endif
        pend_d = w_set | (pend_q & ~w_pause_sent);
        w_load = C_TIMER_W'(ptime_q) * C_TIMER_W'(C_QUANTA_CYCLES / 2);

        timer_d = timer_q;
        if (!pause_req)
            timer_d = '0;
        else if (w_reload)
            timer_d = w_load;
        else if (timer_q != '0)
            timer_d = timer_q - C_TIMER_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            ptime_q     <= '0;
            pend_q      <= 1'b0;
            pause_req_q <= 1'b0;
            timer_q     <= '0;
`ifdef PAUSE_XON_EN
            xon_q       <= 1'b0;
            frame_xon_q <= 1'b0;
`endif
        end else begin
            pend_q      <= pend_d;
            pause_req_q <= pause_req;
            timer_q     <= timer_d;
`ifdef PAUSE_XON_EN
            xon_q       <= xon_d;
`endif
            case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    if (pend_q) begin
                        state_q <= PAUSE;
`ifdef PAUSE_XON_EN
                        ptime_q     <= xon_q ? 16'h0000 : pause_val;
                        frame_xon_q <= xon_q;
`else
                        ptime_q     <= pause_val;
`endif
                    end else if (s_axis_tvalid) begin
                        state_q <= CLIENT;
                    end
                end
                CLIENT: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
                        state_q <= IDLE;
                end
                PAUSE: begin
                    if (m_axis_tready) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == LAST_BEAT)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // CLIENT is a pure passthrough so no latency is added to client frames
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b0;
        case (state_q)
            CLIENT: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
                s_axis_tready = m_axis_tready;
            end
            PAUSE: begin
                m_axis_tdata  = w_gen_tdata;
                m_axis_tkeep  = w_gen_tkeep;
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = w_gen_tlast;
            end
            default: ;
        endcase
    end

    assign pause_sent = w_pause_sent;

endmodule

`default_nettype wire

// File: tb/tb_tx_pause_sched.sv
// ============================================================================
// Module   : tb_tx_pause_sched
// Brief    : Scoreboard bench for tx_pause_sched (honours PAUSE_XON_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tx_pause_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause_req;
    logic [15:0] pause_val;
    logic [47:0] sa;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tready, s_tlast, s_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready, m_tlast, m_tuser;
    logic        pause_sent;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic        is_pause;
        int          gap;
    } beat_t;

    beat_t   exp_q[$];
    int      checks = 0;
    int      errors = 0;
    longint  cyc = 0;
    longint  last_hs = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    tx_pause_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .pause_req           (pause_req),
        .pause_val           (pause_val),
        .cfg_station_macaddr (sa),
        .s_axis_tdata        (s_tdata),
        .s_axis_tkeep        (s_tkeep),
        .s_axis_tvalid       (s_tvalid),
        .s_axis_tready       (s_tready),
        .s_axis_tlast        (s_tlast),
        .s_axis_tuser        (s_tuser),
        .m_axis_tdata        (m_tdata),
        .m_axis_tkeep        (m_tkeep),
        .m_axis_tvalid       (m_tvalid),
        .m_axis_tready       (m_tready),
        .m_axis_tlast        (m_tlast),
        .m_axis_tuser        (m_tuser),
        .pause_sent          (pause_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each downstream handshake
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_tvalid", 64'(m_tvalid), 64'd1);
                chk("stall_tdata", m_tdata, prev_data);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_tdata, e.data);
                    chk("tkeep", 64'(m_tkeep), 64'(e.keep));
                    chk("tlast", 64'(m_tlast), 64'(e.last));
                    chk("tuser", 64'(m_tuser), 64'(e.user));
                    chk("pause_sent", 64'(pause_sent), 64'(e.is_pause & e.last));
                    if (e.gap >= 0)
                        chk("gap", 64'(cyc - last_hs), 64'(e.gap));
                end
                last_hs = cyc;
            end else begin
                chk("pause_sent_nohs", 64'(pause_sent), 64'd0);
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Builds the 60-byte PAUSE frame bytewise, then slices it into beats
    task automatic push_pause(input logic [15:0] pt, input int gap);
        logic [7:0] fb [0:63];
        beat_t e;
        for (int i = 0; i < 64; i++) fb[i] = 8'h00;
        fb[0] = 8'h01; fb[1] = 8'h80; fb[2] = 8'hC2;
        fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
        for (int i = 0; i < 6; i++) fb[6 + i] = sa[47 - 8*i -: 8];
        fb[12] = 8'h88; fb[13] = 8'h08; fb[14] = 8'h00; fb[15] = 8'h01;
        fb[16] = pt[15:8]; fb[17] = pt[7:0];
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                e.data[8*i +: 8] = fb[8*b + i];
                e.keep[i]        = (8*b + i) < 60;
            end
            e.last     = (b == 7);
            e.user     = 1'b0;
            e.is_pause = 1'b1;
            e.gap      = (b == 0) ? gap : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_client(input int n, input logic [7:0] lastkeep, input logic user_last,
                               input int gap, input bit bubble_chk);
        logic [63:0] d[$];
        beat_t e;
        int w;
        for (int b = 0; b < n; b++) begin
            d.push_back({$urandom, $urandom});
            e.data     = d[b];
            e.keep     = (b == n-1) ? lastkeep : 8'hFF;
            e.last     = (b == n-1);
            e.user     = (b == n-1) ? user_last : 1'b0;
            e.is_pause = 1'b0;
            e.gap      = (b == 0) ? gap : -1;
            exp_q.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            s_tdata  = d[b];
            s_tkeep  = (b == n-1) ? lastkeep : 8'hFF;
            s_tlast  = (b == n-1);
            s_tuser  = (b == n-1) ? user_last : 1'b0;
            s_tvalid = 1'b1;
            if (b == 0 && bubble_chk) begin
                @(negedge clk);
                chk("bubble_tvalid", 64'(m_tvalid), 64'd0);
                chk("bubble_tready", 64'(s_tready), 64'd0);
            end
            w = 0;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                w++;
                if (w > 200) break;
            end
            if (b == 0 && bubble_chk) chk("bubble_len", 64'(w), 64'd0);
            if (w > 200) begin
                chk("client_timeout", 64'(w), 64'd0);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        tick(1);
    endtask

    task automatic drop_req();
        pause_req = 1'b0;
`ifdef PAUSE_XON_EN
        push_pause(16'h0000, -1);
`endif
    endtask

    initial begin
        logic [3:0] pat;
        int h, w;
        rst = 1'b1; pause_req = 1'b0; pause_val = '0; sa = 48'h000A35010203;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        m_tready = 1'b1;
        tick(3);

        // Reset state
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_pause_sent", 64'(pause_sent), 64'd0);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Idle client frame with one bubble
        send_client(3, 8'h07, 1'b0, -1, 1'b1);
        wait_drain(50);
        tick(5);

        // PAUSE on request edge; pause_val changed mid-frame must not matter
        pause_val = 16'h0010;
        pause_req = 1'b1;
        push_pause(16'h0010, -1);
        tick(4);
        pause_val = 16'hBEEF;
        wait_drain(100);
        drop_req();
        tick(80);
        wait_drain(100);

        // Request during a client frame; queued client waits for PAUSE tlast
        fork
            begin
                send_client(5, 8'h3F, 1'b1, -1, 1'b0);
                send_client(1, 8'h01, 1'b0, 2, 1'b0);
            end
            begin
                h = 0; w = 0;
                while (h < 2 && w < 200) begin
                    @(negedge clk);
                    if (m_tvalid && m_tready) h++;
                    w++;
                end
                chk("midframe_wait", 64'(h), 64'd2);
                @(posedge clk);
                #1;
                pause_val = 16'h0123;
                pause_req = 1'b1;
                push_pause(16'h0123, 2);
            end
        join
        wait_drain(100);
        drop_req();
        tick(30);
        wait_drain(100);

        // Refresh: ptime 4 -> 16 timer cycles + pend register + IDLE = 18
        pause_val = 16'h0004;
        pause_req = 1'b1;
        push_pause(16'h0004, -1);
        push_pause(16'h0004, 18);
        wait_drain(200);
        drop_req();
        tick(40);
        wait_drain(100);

        // ptime 0: exactly one frame, no refresh
        pause_val = 16'h0000;
        pause_req = 1'b1;
        push_pause(16'h0000, -1);
        wait_drain(100);
        tick(60);
        drop_req();
        tick(30);
        wait_drain(100);

        // Backpressure 1,0,0,1 during a PAUSE frame
        pause_val = 16'h0042;
        pause_req = 1'b1;
        push_pause(16'h0042, -1);
        pat = 4'b1001;
        for (int i = 0; i < 40; i++) begin
            m_tready = pat[i % 4];
            tick(1);
        end
        m_tready = 1'b1;
        wait_drain(100);
        drop_req();
        tick(60);
        wait_drain(100);

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
